mem_port_arbiter: RTL and testbench

- Shares the CPU's single byte-wide RAM port between two requesters: instruction fetch (IF, 4-byte read) and the MEM stage (1/2/4-byte load/store).
- Serialises each request into byte beats, assembles read data little-endian and returns one done pulse per transaction.
- Sits between the IF/MEM stage modules and the top-level RAM/IO bus; the pipeline controller's IF clear drives if_flush_in.

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/mem_port_arbiter_sequencer.sv | 88 ++++++++
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the byte-wide RAM port arbiter.
// Build option: IO_WRITE_STALL_EN (see mem_port_arbiter.sv).
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IF_RD  = 2'd1,
    ST_MEM_RD = 2'd2,
    ST_MEM_WR = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Address bits [17:16] equal to this select the memory-mapped IO window.
  localparam logic [1:0] IO_SEL = 2'b11;

  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_sequencer.sv
// mem_byte_sequencer: beat counter, byte address generation and little-endian
// byte-lane assembly (reads) / extraction (writes) for one transaction.
module mem_byte_sequencer
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [2:0]            nbytes_i,
  input  logic [31:0]           wdata_i,
  input  logic                  step_i,
  input  logic                  capture_i,
  input  logic [7:0]            ram_din_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [7:0]            wbyte_o,
  output logic                  byte_pending_o,
  output logic                  last_beat_o,
  output logic                  all_beats_o,
  output logic                  io_sel_o,
  output logic [31:0]           rdata_o
);

  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [2:0]            n_q, n_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           asm_q, asm_d;
  logic [1:0]            lane;

  assign addr_o         = base_q + {{(ADDR_WIDTH-3){1'b0}}, cnt_q};
  assign byte_pending_o = (cnt_q != 3'd0);
  assign last_beat_o    = (cnt_q == n_q - 3'd1);
  assign all_beats_o    = (cnt_q == n_q);
  assign io_sel_o       = (base_q[17:16] == IO_SEL);

  // ram_din carries the byte addressed one beat earlier, hence lane cnt-1.
  assign lane    = cnt_q[1:0] - 2'd1;
  assign rdata_o = asm_q | ({24'd0, ram_din_i} << {lane, 3'b000});

  always_comb begin
    wbyte_o = wdata_q[7:0];
    case (cnt_q[1:0])
      2'd1:    wbyte_o = wdata_q[15:8];
      2'd2:    wbyte_o = wdata_q[23:16];
      2'd3:    wbyte_o = wdata_q[31:24];
      default: wbyte_o = wdata_q[7:0];
    endcase
  end

  always_comb begin
    base_d  = base_q;
    n_d     = n_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    if (start_i) begin
      base_d  = base_i;
      n_d     = nbytes_i;
      wdata_d = wdata_i;
      cnt_d   = 3'd0;
      asm_d   = 32'd0;
    end else begin
      if (step_i)    cnt_d = cnt_q + 3'd1;
      if (capture_i) asm_d = rdata_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q  <= '0;
      n_q     <= 3'd0;
      wdata_q <= 32'd0;
      cnt_q   <= 3'd0;
      asm_q   <= 32'd0;
    end else if (en_i) begin
      base_q  <= base_d;
      n_q     <= n_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM requests onto a single byte-wide RAM port.
// Build option: define IO_WRITE_STALL_EN to stall IO-window stores while io_buffer_full.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int IF_BYTES   = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  if_req_in,
  input  logic [ADDR_WIDTH-1:0] if_addr_in,
  input  logic                  if_flush_in,
  output logic                  if_done_out,
  output logic [31:0]           if_data_out,
  input  logic                  mem_req_in,
  input  logic                  mem_we_in,
  input  logic [1:0]            mem_size_in,
  input  logic [ADDR_WIDTH-1:0] mem_addr_in,
  input  logic [31:0]           mem_wdata_in,
  output logic                  mem_done_out,
  output logic [31:0]           mem_rdata_out,
  input  logic [7:0]            ram_din,
  output logic [7:0]            ram_dout,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_wr,
  input  logic                  io_buffer_full
);

  state_e                state_q, state_d;
  logic                  if_done_q, if_done_d;
  logic                  mem_done_q, mem_done_d;
  logic [31:0]           if_data_q, if_data_d;
  logic [31:0]           mem_data_q, mem_data_d;

  logic                  seq_start, seq_step, seq_capture;
  logic [ADDR_WIDTH-1:0] seq_base, seq_addr;
  logic [2:0]            seq_n;
  logic [7:0]            seq_wbyte;
  logic [31:0]           seq_rdata;
  logic                  seq_pending, seq_last, seq_all, seq_io;
  logic                  wr_c, wr_stall;

`ifdef IO_WRITE_STALL_EN
  assign wr_stall = seq_io & io_buffer_full;
`else
  logic io_unused;
  assign io_unused = seq_io ^ io_buffer_full;
  assign wr_stall  = 1'b0;
`endif

  mem_byte_sequencer #(.ADDR_WIDTH(ADDR_WIDTH)) u_seq (
    .clk_i          (clk_in),
    .rst_ni         (rst_in),
    .en_i           (rdy_in),
    .start_i        (seq_start),
    .base_i         (seq_base),
    .nbytes_i       (seq_n),
    .wdata_i        (mem_wdata_in),
    .step_i         (seq_step),
    .capture_i      (seq_capture),
    .ram_din_i      (ram_din),
    .addr_o         (seq_addr),
    .wbyte_o        (seq_wbyte),
    .byte_pending_o (seq_pending),
    .last_beat_o    (seq_last),
    .all_beats_o    (seq_all),
    .io_sel_o       (seq_io),
    .rdata_o        (seq_rdata)
  );

  always_comb begin
    state_d     = state_q;
    seq_start   = 1'b0;
    seq_base    = mem_addr_in;
    seq_n       = size_to_bytes(mem_size_in);
    seq_step    = 1'b0;
    seq_capture = 1'b0;
    wr_c        = 1'b0;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_data_d  = mem_data_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_req_in) begin
          seq_start = 1'b1;
          state_d   = mem_we_in ? ST_MEM_WR : ST_MEM_RD;
        end else if (if_req_in && !if_flush_in) begin
          seq_start = 1'b1;
          seq_base  = if_addr_in;
          seq_n     = 3'(IF_BYTES);
          state_d   = ST_IF_RD;
        end
      end
      ST_IF_RD: begin
        // A flush drops the fetch but lets a waiting MEM request in at once.
        if (if_flush_in) begin
          state_d = ST_IDLE;
          if (mem_req_in) begin
            seq_start = 1'b1;
            state_d   = mem_we_in ? ST_MEM_WR : ST_MEM_RD;
          end
        end else begin
          seq_step    = !seq_all;
          seq_capture = seq_pending;
          if (seq_all) begin
            if_data_d = seq_rdata;
            if_done_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_MEM_RD: begin
        seq_step    = !seq_all;
        seq_capture = seq_pending;
        if (seq_all) begin
          mem_data_d = seq_rdata;
          mem_done_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_MEM_WR: begin
        if (!wr_stall) begin
          wr_c     = 1'b1;
          seq_step = 1'b1;
          if (seq_last) begin
            mem_done_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      if_data_q  <= 32'd0;
      mem_data_q <= 32'd0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      if_done_q  <= if_done_d;
      mem_done_q <= mem_done_d;
      if_data_q  <= if_data_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Done flags hold through a freeze; gating keeps the pulse to one live cycle.
  assign if_done_out   = if_done_q & rdy_in;
  assign mem_done_out  = mem_done_q & rdy_in;
  assign if_data_out   = if_data_q;
  assign mem_rdata_out = mem_data_q;
  assign ram_wr        = wr_c & rdy_in;
  assign ram_a         = (state_q == ST_IDLE) ? '0 : seq_addr;
  assign ram_dout      = (state_q == ST_MEM_WR) ? seq_wbyte : 8'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a one-cycle-latency byte RAM model.
module tb_mem_port_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        if_req_in, if_flush_in, if_done_out;
  logic [31:0] if_addr_in, if_data_out;
  logic        mem_req_in, mem_we_in, mem_done_out;
  logic [1:0]  mem_size_in;
  logic [31:0] mem_addr_in, mem_wdata_in, mem_rdata_out;
  logic [7:0]  ram_din = 8'd0;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr, io_buffer_full;

  logic [7:0]  mem [0:16383];
  logic [7:0]  st_bytes [0:3];
  int          checks = 0;
  int          errors = 0;

  mem_port_arbiter #(.ADDR_WIDTH(32), .IF_BYTES(4)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .if_req_in      (if_req_in),
    .if_addr_in     (if_addr_in),
    .if_flush_in    (if_flush_in),
    .if_done_out    (if_done_out),
    .if_data_out    (if_data_out),
    .mem_req_in     (mem_req_in),
    .mem_we_in      (mem_we_in),
    .mem_size_in    (mem_size_in),
    .mem_addr_in    (mem_addr_in),
    .mem_wdata_in   (mem_wdata_in),
    .mem_done_out   (mem_done_out),
    .mem_rdata_out  (mem_rdata_out),
    .ram_din        (ram_din),
    .ram_dout       (ram_dout),
    .ram_a          (ram_a),
    .ram_wr         (ram_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  // Read data follows the address by one cycle and is frozen while rdy_in is low.
  always @(posedge clk_in) begin
    if (rdy_in) ram_din <= mem[ram_a[13:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h100] = 8'h13; mem[14'h101] = 8'h05; mem[14'h102] = 8'h00; mem[14'h103] = 8'h00;
    mem[14'h010] = 8'hA5;
    mem[14'h200] = 8'h93; mem[14'h201] = 8'h00; mem[14'h202] = 8'h10; mem[14'h203] = 8'h00;
    mem[14'h300] = 8'h11; mem[14'h301] = 8'h22; mem[14'h302] = 8'h33; mem[14'h303] = 8'h44;
    mem[14'h040] = 8'h34; mem[14'h041] = 8'h12;
    st_bytes[0] = 8'hEF; st_bytes[1] = 8'hBE; st_bytes[2] = 8'hAD; st_bytes[3] = 8'hDE;

    rst_in = 1'b0; rdy_in = 1'b1;
    if_req_in = 1'b0; if_addr_in = 32'd0; if_flush_in = 1'b0;
    mem_req_in = 1'b0; mem_we_in = 1'b0; mem_size_in = 2'b00;
    mem_addr_in = 32'd0; mem_wdata_in = 32'd0; io_buffer_full = 1'b0;

    #12;
    chk("rst_ram_a", ram_a, 32'd0);
    chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    chk("rst_if_done", {31'd0, if_done_out}, 32'd0);
    chk("rst_mem_done", {31'd0, mem_done_out}, 32'd0);
    chk("rst_if_data", if_data_out, 32'd0);
    chk("rst_mem_rdata", mem_rdata_out, 32'd0);
    tick(); rst_in = 1'b1;

    // IF word fetch from 0x100
    tick(); if_req_in = 1'b1; if_addr_in = 32'h100; #2;
    chk("t1_idle_addr", ram_a, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick(); #2;
      chk($sformatf("t1_addr%0d", k), ram_a, 32'h100 + k);
      chk($sformatf("t1_nodone%0d", k), {31'd0, if_done_out}, 32'd0);
    end
    tick(); #2;
    chk("t1_done_early", {31'd0, if_done_out}, 32'd0);
    tick(); if_req_in = 1'b0; #2;
    chk("t1_done", {31'd0, if_done_out}, 32'd1);
    chk("t1_data", if_data_out, 32'h00000513);
    tick(); #2;
    chk("t1_pulse_end", {31'd0, if_done_out}, 32'd0);
    chk("t1_data_hold", if_data_out, 32'h00000513);

    // MEM store word 0xDEADBEEF to 0x2000; inputs scrambled after grant
    tick(); mem_req_in = 1'b1; mem_we_in = 1'b1; mem_size_in = 2'b10;
    mem_addr_in = 32'h2000; mem_wdata_in = 32'hDEADBEEF; #2;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) begin mem_addr_in = 32'h5555; mem_wdata_in = 32'h0; end
      #2;
      chk($sformatf("t2_wr%0d", k), {31'd0, ram_wr}, 32'd1);
      chk($sformatf("t2_addr%0d", k), ram_a, 32'h2000 + k);
      chk($sformatf("t2_dout%0d", k), {24'd0, ram_dout}, {24'd0, st_bytes[k]});
      chk($sformatf("t2_nodone%0d", k), {31'd0, mem_done_out}, 32'd0);
    end
    tick(); mem_req_in = 1'b0; mem_we_in = 1'b0; #2;
    chk("t2_done", {31'd0, mem_done_out}, 32'd1);
    chk("t2_wr_off", {31'd0, ram_wr}, 32'd0);
    tick(); #2;
    chk("t2_pulse_end", {31'd0, mem_done_out}, 32'd0);

    // Simultaneous IF and MEM byte load at 0x10: MEM first
    tick(); if_req_in = 1'b1; if_addr_in = 32'h100;
    mem_req_in = 1'b1; mem_we_in = 1'b0; mem_size_in = 2'b00; mem_addr_in = 32'h10; #2;
    tick(); #2;
    chk("t3_mem_addr", ram_a, 32'h10);
    tick(); #2;
    tick(); mem_req_in = 1'b0; #2;
    chk("t3_mem_done", {31'd0, mem_done_out}, 32'd1);
    chk("t3_mem_rdata", mem_rdata_out, 32'h000000A5);
    chk("t3_idle_in_done", ram_a, 32'd0);
    chk("t3_if_not_done", {31'd0, if_done_out}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick(); #2;
      chk($sformatf("t3_if_addr%0d", k), ram_a, 32'h100 + k);
    end
    tick(); #2;
    tick(); if_req_in = 1'b0; #2;
    chk("t3_if_done", {31'd0, if_done_out}, 32'd1);
    chk("t3_if_data", if_data_out, 32'h00000513);

    // IF flush at beat 2, then a fresh fetch from 0x200
    tick(); if_req_in = 1'b1; if_addr_in = 32'h300; #2;
    tick(); #2; chk("t4_addr0", ram_a, 32'h300);
    tick(); #2; chk("t4_addr1", ram_a, 32'h301);
    tick(); if_flush_in = 1'b1; if_req_in = 1'b0; #2;
    chk("t4_addr2", ram_a, 32'h302);
    tick(); if_flush_in = 1'b0; #2;
    chk("t4_flush_idle", ram_a, 32'd0);
    chk("t4_no_done0", {31'd0, if_done_out}, 32'd0);
    tick(); #2;
    chk("t4_no_done1", {31'd0, if_done_out}, 32'd0);
    tick(); if_req_in = 1'b1; if_addr_in = 32'h200; #2;
    chk("t4_no_done2", {31'd0, if_done_out}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick(); #2;
      chk($sformatf("t4_new_addr%0d", k), ram_a, 32'h200 + k);
    end
    tick(); #2;
    tick(); if_req_in = 1'b0; #2;
    chk("t4_done", {31'd0, if_done_out}, 32'd1);
    chk("t4_data", if_data_out, 32'h00100093);

    // Half-word load at 0x40 frozen for 3 cycles
    tick(); mem_req_in = 1'b1; mem_we_in = 1'b0; mem_size_in = 2'b01; mem_addr_in = 32'h40; #2;
    tick(); #2; chk("t5_addr0", ram_a, 32'h40);
    for (int s = 0; s < 3; s++) begin
      tick(); rdy_in = 1'b0; #2;
      chk($sformatf("t5_hold_addr%0d", s), ram_a, 32'h41);
      chk($sformatf("t5_hold_wr%0d", s), {31'd0, ram_wr}, 32'd0);
      chk($sformatf("t5_hold_done%0d", s), {31'd0, mem_done_out}, 32'd0);
    end
    tick(); rdy_in = 1'b1; #2;
    chk("t5_resume_addr", ram_a, 32'h41);
    tick(); #2;
    chk("t5_no_done", {31'd0, mem_done_out}, 32'd0);
    tick(); mem_req_in = 1'b0; #2;
    chk("t5_done", {31'd0, mem_done_out}, 32'd1);
    chk("t5_rdata", mem_rdata_out, 32'h00001234);

    // Byte store with a one-cycle freeze on its beat
    tick(); mem_req_in = 1'b1; mem_we_in = 1'b1; mem_size_in = 2'b00;
    mem_addr_in = 32'h2100; mem_wdata_in = 32'h0000005A; #2;
    tick(); rdy_in = 1'b0; #2;
    chk("t5b_frozen_wr", {31'd0, ram_wr}, 32'd0);
    chk("t5b_frozen_addr", ram_a, 32'h2100);
    tick(); rdy_in = 1'b1; #2;
    chk("t5b_wr", {31'd0, ram_wr}, 32'd1);
    chk("t5b_dout", {24'd0, ram_dout}, 32'h5A);
    tick(); mem_req_in = 1'b0; mem_we_in = 1'b0; #2;
    chk("t5b_done", {31'd0, mem_done_out}, 32'd1);

    // Asynchronous reset in the middle of a word store
    tick(); mem_req_in = 1'b1; mem_we_in = 1'b1; mem_size_in = 2'b10;
    mem_addr_in = 32'h2200; mem_wdata_in = 32'hCAFEF00D; #2;
    tick(); #2; chk("t6_wr_before", {31'd0, ram_wr}, 32'd1);
    tick(); #2; chk("t6_addr_before", ram_a, 32'h2201);
    rst_in = 1'b0; #1;
    chk("t6_rst_addr", ram_a, 32'd0);
    chk("t6_rst_wr", {31'd0, ram_wr}, 32'd0);
    chk("t6_rst_dout", {24'd0, ram_dout}, 32'd0);
    chk("t6_rst_if_data", if_data_out, 32'd0);
    chk("t6_rst_mem_rdata", mem_rdata_out, 32'd0);
    mem_req_in = 1'b0; mem_we_in = 1'b0;
    tick(); rst_in = 1'b1; #2;
    chk("t6_post_rst_idle", ram_a, 32'd0);

    // Byte store 0x41 into the IO window while the buffer reports full
    tick(); mem_req_in = 1'b1; mem_we_in = 1'b1; mem_size_in = 2'b00;
    mem_addr_in = 32'h30000; mem_wdata_in = 32'h00000041; io_buffer_full = 1'b1; #2;
`ifdef IO_WRITE_STALL_EN
    for (int s = 0; s < 5; s++) begin
      tick(); #2;
      chk($sformatf("t7_stall_wr%0d", s), {31'd0, ram_wr}, 32'd0);
      chk($sformatf("t7_stall_done%0d", s), {31'd0, mem_done_out}, 32'd0);
    end
    tick(); io_buffer_full = 1'b0; #2;
`else
    tick(); #2;
`endif
    chk("t7_wr", {31'd0, ram_wr}, 32'd1);
    chk("t7_addr", ram_a, 32'h30000);
    chk("t7_dout", {24'd0, ram_dout}, 32'h41);
    tick(); mem_req_in = 1'b0; mem_we_in = 1'b0; io_buffer_full = 1'b0; #2;
    chk("t7_done", {31'd0, mem_done_out}, 32'd1);
    chk("t7_wr_off", {31'd0, ram_wr}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
